counter_bank: RTL and testbench
===============================

// Module: counter_bank
// PURPOSE
//  Parametrised bank of NUM_CH independent up/down counters, each with its own
//  sys_clk prescaler, wrap/saturate mode, compare value and edge-pulse triggers.
//  Sits between host endpoint wires/triggers and the user logic. Count values
//  feed wire-outs; trigger pulses feed trigger-outs (clocked by sys_clk).
// PARAMETERS
//  NUM_CH     2   number of counter channels (1..16)
//  CNT_WIDTH  8   counter width in bits (2..32)
//  DIV_WIDTH  24  prescaler width in bits (1..32)
// PORTS
//  sys_clk     in   1                  single clock, all logic on posedge
//  reset       in   1                  synchronous, active-high, whole bank
//  ch_reset    in   NUM_CH             per-channel sync clear of count
//  ch_enable   in   NUM_CH             1 = auto-count from prescaler tick
//  ch_up       in   NUM_CH             1-cycle pulse: increment
//  ch_down     in   NUM_CH             1-cycle pulse: decrement
//  ch_sat      in   NUM_CH             0 = wrap, 1 = saturate
//  div_reload  in   NUM_CH*DIV_WIDTH   prescaler reload, ch i at [i*DIV_WIDTH +: DIV_WIDTH]
//  cmp_value   in   NUM_CH*CNT_WIDTH   compare value, ch i at [i*CNT_WIDTH +: CNT_WIDTH]
//  count_out   out  NUM_CH*CNT_WIDTH   registered counts, same packing as cmp_value
//  zero_trig   out  NUM_CH             1-cycle pulse: count entered 0
//  cmp_trig    out  NUM_CH             1-cycle pulse: count entered cmp_value
//  max_trig    out  NUM_CH             1-cycle pulse: count entered all-ones
//  snap_req    in   1                  snapshot request (see CONFIGURATION)
//  snap_out    out  NUM_CH*CNT_WIDTH   snapshot of all counts
//  snap_valid  out  1                  1-cycle pulse: snap_out updated
// BEHAVIOUR
//  Reset: count=0, div=div_reload, tick=0; all trig=0, snap_out=0, snap_valid=0.
//   Internal "was-zero" flags = 1 and "was-cmp" flags = (cmp_value==0), so no
//   trigger fires merely because reset was released.
//  Prescaler per ch: div decrements every cycle, free-running (ignores ch_enable).
//   On div==0: reload from div_reload, and tick asserts the next cycle for one
//   cycle. Period = reload+1 cycles; reload=0 gives a tick every cycle.
//   div_reload is sampled only at reload; changes take effect after current period.
//  Count update per ch, one edge after the input, priority order:
//   1 ch_reset -> 0
//   2 ch_up & ch_down together -> hold (tick is discarded)
//   3 ch_up -> +1 ; ch_down -> -1 (a tick in the same cycle is discarded)
//   4 ch_enable & tick -> +1
//   5 otherwise hold
//  Wrap mode: max+1 -> 0, 0-1 -> max. Saturate mode: stays at max / stays at 0.
//   ch_sat may change at any time; it applies to the next update only.
//  Triggers: registered, asserted the cycle after count takes the value. They are
//   edge pulses: asserted only if the condition is true now and was false in the
//   previous cycle. A count held at the value never re-fires; saturating at max
//   fires max_trig once. cmp_trig compares against live cmp_value, so changing
//   cmp_value to equal the held count fires once.
//   Several triggers may pulse together (e.g. cmp_value=0 with zero_trig).
//  Channels are fully independent; reset overrides all activity mid-operation.
// CONFIGURATION
//  COUNTER_BANK_SNAPSHOT_EN defined: snap_req high in cycle N captures all
//   count_out values present in cycle N into snap_out at edge N+1 (coherent
//   across channels); snap_valid pulses in cycle N+1. Back-to-back requests
//   recapture every cycle. snap_out holds its value between requests.
//  Not defined: snapshot logic is omitted; snap_out=0 and snap_valid=0
//   constantly; snap_req is ignored.
// TESTING
//  1 Reset, ch0 reload=3, enable=1 -> count0 increments every 4 cycles; ch1 stays 0.
//  2 CNT_WIDTH=8, wrap, count=8'hFE, two up pulses -> FF then 00; max_trig pulses
//    once at FF, zero_trig pulses once at 00.
//  3 Saturate, count=FF, 3 up pulses -> stays FF, max_trig single pulse only;
//    at 0, down -> stays 0, no zero_trig.
//  4 Up+down in the same cycle as a tick -> count holds. Up in a tick cycle -> +1 only.
//  5 count=5, ch_reset mid-prescaler -> count 0 next edge, zero_trig next cycle;
//    cmp_value set to 0x05 later -> cmp_trig when count next reaches 5.
//  6 SNAPSHOT_EN: channels at 0x12/0x34, snap_req 1 cycle -> snap_out={34,12}
//    and snap_valid pulse the next cycle. Macro undefined: snap_out stays 0.

Source files
------------

// File: rtl/counter_bank.sv
// Bank of NUM_CH independent up/down counters with free-running prescalers, wrap/saturate
// modes and edge-pulse triggers. Optional coherent snapshot: COUNTER_BANK_SNAPSHOT_EN.
module counter_bank #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned DIV_WIDTH = 24
) (
    input  logic                          sys_clk_i,
    input  logic                          reset_i,
    input  logic [NUM_CH-1:0]             ch_reset_i,
    input  logic [NUM_CH-1:0]             ch_enable_i,
    input  logic [NUM_CH-1:0]             ch_up_i,
    input  logic [NUM_CH-1:0]             ch_down_i,
    input  logic [NUM_CH-1:0]             ch_sat_i,
    input  logic [NUM_CH*DIV_WIDTH-1:0]   div_reload_i,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   cmp_value_i,
    output logic [NUM_CH*CNT_WIDTH-1:0]   count_out_o,
    output logic [NUM_CH-1:0]             zero_trig_o,
    output logic [NUM_CH-1:0]             cmp_trig_o,
    output logic [NUM_CH-1:0]             max_trig_o,
    input  logic                          snap_req_i,
    output logic [NUM_CH*CNT_WIDTH-1:0]   snap_out_o,
    output logic                          snap_valid_o
);

    localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DivOne = DIV_WIDTH'(1);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_WIDTH-1:0] reload;
        logic [DIV_WIDTH-1:0] div_q, div_d;
        logic                 tick_q, tick_d;
        logic [CNT_WIDTH-1:0] cmp;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [CNT_WIDTH-1:0] inc_val, dec_val;
        logic                 zero_now, cmp_now, max_now;
        logic                 was_zero_q, was_cmp_q, was_max_q;
        logic                 zero_trig_q, cmp_trig_q, max_trig_q;

        assign reload = div_reload_i[g*DIV_WIDTH +: DIV_WIDTH];
        assign cmp    = cmp_value_i[g*CNT_WIDTH +: CNT_WIDTH];

        // Prescaler runs regardless of ch_enable; reload value is only sampled at wrap.
        always_comb begin
            div_d  = div_q - DivOne;
            tick_d = 1'b0;
            if (div_q == '0) begin
                div_d  = reload;
                tick_d = 1'b1;
            end
        end

        assign inc_val = (ch_sat_i[g] && (cnt_q == CntMax)) ? cnt_q : cnt_q + CntOne;
        assign dec_val = (ch_sat_i[g] && (cnt_q == '0))     ? cnt_q : cnt_q - CntOne;

        // Manual pulses take precedence over (and swallow) a coincident prescaler tick.
        always_comb begin
            cnt_d = cnt_q;
            if (ch_reset_i[g]) begin
                cnt_d = '0;
            end else if (ch_up_i[g] && ch_down_i[g]) begin
                cnt_d = cnt_q;
            end else if (ch_up_i[g]) begin
                cnt_d = inc_val;
            end else if (ch_down_i[g]) begin
                cnt_d = dec_val;
            end else if (ch_enable_i[g] && tick_q) begin
                cnt_d = inc_val;
            end
        end

        assign zero_now = (cnt_q == '0);
        assign cmp_now  = (cnt_q == cmp);
        assign max_now  = (cnt_q == CntMax);

        always_ff @(posedge sys_clk_i) begin
            if (reset_i) begin
                div_q       <= reload;
                tick_q      <= 1'b0;
                cnt_q       <= '0;
                // Seed history to match the post-reset count so release fires nothing.
                was_zero_q  <= 1'b1;
                was_cmp_q   <= (cmp == '0);
                was_max_q   <= 1'b0;
                zero_trig_q <= 1'b0;
                cmp_trig_q  <= 1'b0;
                max_trig_q  <= 1'b0;
            end else begin
                div_q       <= div_d;
                tick_q      <= tick_d;
                cnt_q       <= cnt_d;
                was_zero_q  <= zero_now;
                was_cmp_q   <= cmp_now;
                was_max_q   <= max_now;
                zero_trig_q <= zero_now & ~was_zero_q;
                cmp_trig_q  <= cmp_now & ~was_cmp_q;
                max_trig_q  <= max_now & ~was_max_q;
            end
        end

        assign count_out_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        assign zero_trig_o[g] = zero_trig_q;
        assign cmp_trig_o[g]  = cmp_trig_q;
        assign max_trig_o[g]  = max_trig_q;
    end

`ifdef COUNTER_BANK_SNAPSHOT_EN
    logic [NUM_CH*CNT_WIDTH-1:0] snap_q;
    logic                        snap_valid_q;

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_valid_q <= snap_req_i;
            if (snap_req_i) begin
                snap_q <= count_out_o;
            end
        end
    end

    assign snap_out_o   = snap_q;
    assign snap_valid_o = snap_valid_q;
`else
    logic unused_snap_req;
    assign unused_snap_req = snap_req_i;
    assign snap_out_o      = '0;
    assign snap_valid_o    = 1'b0;
`endif

endmodule

// File: tb/tb_counter_bank.sv
// Directed self-checking bench for counter_bank (2 channels, 8-bit counts).
module tb_counter_bank;

    logic        clk;
    logic        reset;
    logic [1:0]  ch_reset, ch_enable, ch_up, ch_down, ch_sat;
    logic [47:0] div_reload;
    logic [15:0] cmp_value;
    logic [15:0] count_out;
    logic [1:0]  zero_trig, cmp_trig, max_trig;
    logic        snap_req;
    logic [15:0] snap_out;
    logic        snap_valid;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_snap;
    logic        exp_snap_valid;

    counter_bank #(
        .NUM_CH   (2),
        .CNT_WIDTH(8),
        .DIV_WIDTH(24)
    ) dut (
        .sys_clk_i   (clk),
        .reset_i     (reset),
        .ch_reset_i  (ch_reset),
        .ch_enable_i (ch_enable),
        .ch_up_i     (ch_up),
        .ch_down_i   (ch_down),
        .ch_sat_i    (ch_sat),
        .div_reload_i(div_reload),
        .cmp_value_i (cmp_value),
        .count_out_o (count_out),
        .zero_trig_o (zero_trig),
        .cmp_trig_o  (cmp_trig),
        .max_trig_o  (max_trig),
        .snap_req_i  (snap_req),
        .snap_out_o  (snap_out),
        .snap_valid_o(snap_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b1;
        ch_reset   = '0;
        ch_enable  = '0;
        ch_up      = '0;
        ch_down    = '0;
        ch_sat     = '0;
        div_reload = {24'd0, 24'd3};
        cmp_value  = {8'h50, 8'h50};
        snap_req   = 1'b0;
        step();
        step();

        chk("rst_count", 32'(count_out), 32'h0);
        chk("rst_zero_trig", 32'(zero_trig), 32'h0);
        chk("rst_cmp_trig", 32'(cmp_trig), 32'h0);
        chk("rst_max_trig", 32'(max_trig), 32'h0);
        chk("rst_snap_out", 32'(snap_out), 32'h0);
        chk("rst_snap_valid", 32'(snap_valid), 32'h0);

        // Prescaler reload 3 -> one increment every 4 cycles, first at edge 5.
        reset     = 1'b0;
        ch_enable = 2'b01;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("presc_cnt0", 32'(count_out[7:0]), 32'((k - 1) / 4));
        end
        chk("presc_cnt1_idle", 32'(count_out[15:8]), 32'h0);
        chk("presc_no_trig", 32'(zero_trig | max_trig | cmp_trig), 32'h0);
        ch_enable = 2'b00;

        // ch1 reload 0 ticks every cycle.
        ch_enable = 2'b10;
        step();
        chk("tick_cnt1", 32'(count_out[15:8]), 32'h1);
        ch_up   = 2'b10;
        ch_down = 2'b10;
        step();
        chk("updown_hold", 32'(count_out[15:8]), 32'h1);
        ch_down = 2'b00;
        step();
        chk("up_in_tick", 32'(count_out[15:8]), 32'h2);
        ch_up     = 2'b00;
        ch_enable = 2'b00;
        step();
        chk("ch1_hold", 32'(count_out[15:8]), 32'h2);
        chk("ch0_indep", 32'(count_out[7:0]), 32'h2);

        // ch_reset and compare trigger.
        ch_up = 2'b01;
        repeat (3) step();
        ch_up = 2'b00;
        chk("cnt0_at5", 32'(count_out[7:0]), 32'h5);
        ch_reset = 2'b01;
        step();
        chk("chrst_cnt0", 32'(count_out[7:0]), 32'h0);
        chk("chrst_zero_early", 32'(zero_trig), 32'h0);
        ch_reset = 2'b00;
        step();
        chk("chrst_zero_trig", 32'(zero_trig), 32'h1);
        step();
        chk("chrst_zero_once", 32'(zero_trig), 32'h0);
        cmp_value[7:0] = 8'h05;
        step();
        chk("cmp_not_yet", 32'(cmp_trig), 32'h0);
        ch_up = 2'b01;
        repeat (5) step();
        ch_up = 2'b00;
        chk("cmp_cnt5", 32'(count_out[7:0]), 32'h5);
        chk("cmp_trig_lag", 32'(cmp_trig), 32'h0);
        step();
        chk("cmp_trig", 32'(cmp_trig), 32'h1);
        step();
        chk("cmp_trig_once", 32'(cmp_trig), 32'h0);
        cmp_value[7:0] = 8'h07;
        step();
        cmp_value[7:0] = 8'h05;
        step();
        chk("cmp_live_change", 32'(cmp_trig), 32'h1);
        step();
        chk("cmp_live_once", 32'(cmp_trig), 32'h0);

        // Wrap mode across FF -> 00.
        ch_reset = 2'b01;
        step();
        ch_reset = 2'b00;
        ch_down  = 2'b01;
        step();
        step();
        ch_down = 2'b00;
        step();
        step();
        chk("wrap_start_fe", 32'(count_out[7:0]), 32'hFE);
        ch_up = 2'b01;
        step();
        chk("wrap_ff", 32'(count_out[7:0]), 32'hFF);
        chk("wrap_max_lag", 32'(max_trig), 32'h0);
        step();
        chk("wrap_00", 32'(count_out[7:0]), 32'h00);
        chk("wrap_max_trig", 32'(max_trig), 32'h1);
        chk("wrap_zero_lag", 32'(zero_trig), 32'h0);
        ch_up = 2'b00;
        step();
        chk("wrap_max_once", 32'(max_trig), 32'h0);
        chk("wrap_zero_trig", 32'(zero_trig), 32'h1);
        step();
        chk("wrap_zero_once", 32'(zero_trig), 32'h0);

        // Saturate mode at both ends.
        ch_sat  = 2'b01;
        ch_down = 2'b01;
        step();
        chk("sat_floor", 32'(count_out[7:0]), 32'h00);
        ch_down = 2'b00;
        step();
        chk("sat_floor_no_zero", 32'(zero_trig), 32'h0);
        step();
        chk("sat_floor_no_zero2", 32'(zero_trig), 32'h0);
        ch_sat  = 2'b00;
        ch_down = 2'b01;
        step();
        chk("sat_to_ff", 32'(count_out[7:0]), 32'hFF);
        ch_down = 2'b00;
        ch_sat  = 2'b01;
        ch_up   = 2'b01;
        step();
        chk("sat_ceiling1", 32'(count_out[7:0]), 32'hFF);
        chk("sat_max_trig", 32'(max_trig), 32'h1);
        step();
        chk("sat_ceiling2", 32'(count_out[7:0]), 32'hFF);
        chk("sat_max_once2", 32'(max_trig), 32'h0);
        step();
        chk("sat_ceiling3", 32'(count_out[7:0]), 32'hFF);
        chk("sat_max_once3", 32'(max_trig), 32'h0);
        ch_up = 2'b00;
        step();
        chk("sat_max_once4", 32'(max_trig), 32'h0);

        // Snapshot of 0x12 / 0x34.
        ch_sat   = 2'b00;
        ch_reset = 2'b11;
        step();
        ch_reset = 2'b00;
        for (int i = 0; i < 52; i++) begin
            ch_up = {1'b1, 1'(i < 18)};
            step();
        end
        ch_up = 2'b00;
        chk("snap_counts", 32'(count_out), 32'h3412);
`ifdef COUNTER_BANK_SNAPSHOT_EN
        exp_snap       = 16'h3412;
        exp_snap_valid = 1'b1;
`else
        exp_snap       = 16'h0000;
        exp_snap_valid = 1'b0;
`endif
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        ch_up    = 2'b01;
        chk("snap_out", 32'(snap_out), 32'(exp_snap));
        chk("snap_valid", 32'(snap_valid), 32'(exp_snap_valid));
        step();
        ch_up = 2'b00;
        chk("snap_hold", 32'(snap_out), 32'(exp_snap));
        chk("snap_valid_once", 32'(snap_valid), 32'h0);
        chk("snap_cnt_moved", 32'(count_out[7:0]), 32'h13);

        // Bank reset overrides everything.
        reset = 1'b1;
        ch_up = 2'b11;
        step();
        chk("rst2_count", 32'(count_out), 32'h0);
        chk("rst2_trigs", 32'({zero_trig, cmp_trig, max_trig}), 32'h0);
        chk("rst2_snap", 32'(snap_out), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
